dmem_responder: RTL and testbench

Multi-cycle data-memory responder for the RISC-V core. It is the memory-side end of the control interface produced by the main decoder. It accepts `MemRead`/`MemWrite` requests with a byte address and `Funct3` from the MEM stage. While the access is in progress it holds the pipeline with `Stall`, then completes the access with a one-cycle `Done`. Sub-word lanes are selected and loads are sign- or zero-extended here, so the datapath only ever sees 32-bit values.

---
 rtl/dmem_pkg.sv | 27 ++
 rtl/dmem_if.sv | 22 ++
 rtl/dmem_ram.sv | 28 ++
 rtl/dmem_responder.sv | 153 +++++++++++++++
 tb/tb_dmem_responder.sv | 130 +++++++++++++
 5 files changed

// File: rtl/dmem_pkg.sv
// Shared types for the data-memory responder: FSM states, Funct3 codes, byte-enable helper.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // size is Funct3[1:0]: 00 byte, 01 half, otherwise full word
    function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] lane);
        logic [3:0] be;
        case (size)
            2'b00:   be = 4'b0001 << lane;
            2'b01:   be = lane[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/dmem_if.sv
// MEM-stage request/response bundle between the core (master) and the data-memory responder (slave).
interface dmem_if;
    logic        MemRead;
    logic        MemWrite;
    logic [2:0]  Funct3;
    logic [31:0] Addr;
    logic [31:0] WrData;
    logic [31:0] RdData;
    logic        Stall;
    logic        Done;
    logic        AccessErr;

    modport master (
        output MemRead, MemWrite, Funct3, Addr, WrData,
        input  RdData, Stall, Done, AccessErr
    );

    modport slave (
        input  MemRead, MemWrite, Funct3, Addr, WrData,
        output RdData, Stall, Done, AccessErr
    );
endinterface

// File: rtl/dmem_ram.sv
// DEPTH x 32 RAM with byte enables; read and write both happen on the access edge.
// Read data is registered, so it is valid the cycle after en_i.
module dmem_ram #(
    parameter int DEPTH = 256
) (
    input  logic                     clk,
    input  logic                     en_i,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] idx_i,
    input  logic [3:0]               be_i,
    input  logic [31:0]              wdata_i,
    output logic [31:0]              rdata_o
);

    logic [31:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (en_i) begin
            rdata_o <= mem_q[idx_i];
            if (we_i) begin
                for (int b = 0; b < 4; b++) begin
                    if (be_i[b]) mem_q[idx_i][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: Stall for LATENCY+1 cycles, then a one-cycle Done with RdData/AccessErr.
// Byte/half lanes and load extension exist only when DMEM_SUBWORD_EN is defined; otherwise all accesses are words.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic   clk,
    input  logic   reset,
    dmem_if.slave  bus
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    dmem_state_t   state_q;
    logic [CW-1:0] cnt_q;
    logic          wr_q, err_q, done_q, aerr_q;
    logic [AW-1:0] idx_q;
    logic [3:0]    be_q;
    logic [31:0]   wdat_q, rd_q;

    logic          req, req_err, access, ram_we;
    logic [3:0]    req_be;
    logic [31:0]   req_wdat, ram_rdata, load_val, resp_val;

    assign req = bus.MemRead | bus.MemWrite;

`ifdef DMEM_SUBWORD_EN
    logic [2:0] f3_q;
    logic [1:0] lane_q;
    logic [7:0] byte_v;
    logic [15:0] half_v;
    logic       unused_addr;

    assign unused_addr = ^{bus.Addr[31:AW+2]};

    always_comb begin
        req_err = 1'b0;
        case (bus.Funct3)
            F3_B, F3_BU: req_err = 1'b0;
            F3_H, F3_HU: req_err = bus.Addr[0];
            F3_W:        req_err = (bus.Addr[1:0] != 2'b00);
            default:     req_err = 1'b1;
        endcase
        // Unsigned variants have no store form
        if (bus.MemWrite && bus.Funct3[2]) req_err = 1'b1;
    end

    assign req_be = byte_en(bus.Funct3[1:0], bus.Addr[1:0]);

    always_comb begin
        case (bus.Funct3[1:0])
            2'b00:   req_wdat = {4{bus.WrData[7:0]}};
            2'b01:   req_wdat = {2{bus.WrData[15:0]}};
            default: req_wdat = bus.WrData;
        endcase
    end

    always_ff @(posedge clk) begin
        if (state_q == IDLE && req) begin
            f3_q   <= bus.Funct3;
            lane_q <= bus.Addr[1:0];
        end
    end

    assign byte_v = ram_rdata[{lane_q, 3'b000} +: 8];
    assign half_v = lane_q[1] ? ram_rdata[31:16] : ram_rdata[15:0];

    always_comb begin
        case (f3_q)
            F3_B:    load_val = {{24{byte_v[7]}}, byte_v};
            F3_BU:   load_val = {24'b0, byte_v};
            F3_H:    load_val = {{16{half_v[15]}}, half_v};
            F3_HU:   load_val = {16'b0, half_v};
            default: load_val = ram_rdata;
        endcase
    end
`else
    logic unused_addr;

    assign unused_addr = ^{bus.Addr[31:AW+2], bus.Funct3};
    assign req_err     = (bus.Addr[1:0] != 2'b00);
    assign req_be      = 4'b1111;
    assign req_wdat    = bus.WrData;
    assign load_val    = ram_rdata;
`endif

    assign access = reset && (state_q == WAIT) && (cnt_q == '0);
    assign ram_we = access && wr_q && !err_q;

    dmem_ram #(.DEPTH(DEPTH)) u_ram (
        .clk     (clk),
        .en_i    (access),
        .we_i    (ram_we),
        .idx_i   (idx_q),
        .be_i    (be_q),
        .wdata_i (wdat_q),
        .rdata_o (ram_rdata)
    );

    // A successful store leaves the previous load result visible
    assign resp_val = err_q ? 32'b0 : (wr_q ? rd_q : load_val);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
            aerr_q  <= 1'b0;
            rd_q    <= 32'b0;
        end else begin
            done_q <= 1'b0;
            aerr_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req) begin
                        state_q <= WAIT;
                        cnt_q   <= CW'(LATENCY - 1);
                        wr_q    <= bus.MemWrite;
                        err_q   <= req_err;
                        idx_q   <= bus.Addr[AW+1:2];
                        be_q    <= req_be;
                        wdat_q  <= req_wdat;
                    end
                end
                WAIT: begin
                    if (cnt_q == '0) begin
                        state_q <= RESP;
                        done_q  <= 1'b1;
                        aerr_q  <= err_q;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                    rd_q    <= resp_val;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.Stall     = reset && ((state_q == IDLE && req) || state_q == WAIT);
    assign bus.Done      = done_q;
    assign bus.AccessErr = aerr_q;
    assign bus.RdData    = (state_q == RESP) ? resp_val : rd_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: timing, lanes, errors, reset abort, simultaneous request and wrap.
module tb_dmem_responder;
    import dmem_pkg::*;

    localparam int LAT   = 2;
    localparam int DEPTH = 256;
`ifdef DMEM_SUBWORD_EN
    localparam bit SUB = 1'b1;
`else
    localparam bit SUB = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    int   n_chk = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    dmem_if bus_if ();

    dmem_responder #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if.slave)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic access(input string tag, input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd,
                          input logic exp_err, input logic [31:0] exp_rd);
        logic [31:0] st, dn, rdv;
        logic        ev;
        st = '0; dn = '0; rdv = '0; ev = 1'b0;
        @(negedge clk);
        bus_if.MemRead  = rd;
        bus_if.MemWrite = wr;
        bus_if.Funct3   = f3;
        bus_if.Addr     = a;
        bus_if.WrData   = wd;
        #1;
        for (int c = 0; c <= LAT + 1; c++) begin
            if (c > 0) @(negedge clk);
            st[c] = bus_if.Stall;
            dn[c] = bus_if.Done;
            if (c == LAT + 1) begin
                rdv = bus_if.RdData;
                ev  = bus_if.AccessErr;
            end
        end
        bus_if.MemRead  = 1'b0;
        bus_if.MemWrite = 1'b0;
        check({tag, ".stall"}, st, (32'd1 << (LAT + 1)) - 32'd1);
        check({tag, ".done"},  dn, 32'd1 << (LAT + 1));
        check({tag, ".err"},   {31'b0, ev}, {31'b0, exp_err});
        check({tag, ".rdata"}, rdv, exp_rd);
        @(negedge clk);
        check({tag, ".hold"},  {bus_if.Done, bus_if.AccessErr, 30'b0} | {2'b0, 30'b0} , 32'b0);
        check({tag, ".rdhold"}, bus_if.RdData, exp_rd);
    endtask

    initial begin
        logic [31:0] w10;
        reset           = 1'b0;
        bus_if.MemRead  = 1'b0;
        bus_if.MemWrite = 1'b0;
        bus_if.Funct3   = F3_W;
        bus_if.Addr     = 32'h0;
        bus_if.WrData   = 32'h0;
        repeat (3) @(negedge clk);
        check("rst.stall", {31'b0, bus_if.Stall}, 32'd0);
        check("rst.done",  {31'b0, bus_if.Done}, 32'd0);
        check("rst.err",   {31'b0, bus_if.AccessErr}, 32'd0);
        check("rst.rdata", bus_if.RdData, 32'd0);
        reset = 1'b1;

        w10 = SUB ? 32'h80ADBEEF : 32'hDEADBEEF;
        access("sw10",  1'b0, 1'b1, F3_W,  32'h10, 32'hDEADBEEF, 1'b0, 32'h0);
        access("lw10",  1'b1, 1'b0, F3_W,  32'h10, 32'h0, 1'b0, 32'hDEADBEEF);
        access("sb13",  1'b0, 1'b1, F3_B,  32'h13, 32'h80, !SUB, SUB ? 32'hDEADBEEF : 32'h0);
        access("lb13",  1'b1, 1'b0, F3_B,  32'h13, 32'h0, !SUB, SUB ? 32'hFFFFFF80 : 32'h0);
        access("lbu13", 1'b1, 1'b0, F3_BU, 32'h13, 32'h0, !SUB, SUB ? 32'h00000080 : 32'h0);
        access("lw10b", 1'b1, 1'b0, F3_W,  32'h10, 32'h0, 1'b0, w10);
        access("lhu12", 1'b1, 1'b0, F3_HU, 32'h12, 32'h0, !SUB, SUB ? 32'h000080AD : 32'h0);
        access("lh11",  1'b1, 1'b0, F3_H,  32'h11, 32'h0, 1'b1, 32'h0);
        access("sw12",  1'b0, 1'b1, F3_W,  32'h12, 32'h12345678, 1'b1, 32'h0);
        access("lw10c", 1'b1, 1'b0, F3_W,  32'h10, 32'h0, 1'b0, w10);
        access("ld011", 1'b1, 1'b0, 3'b011, 32'h10, 32'h0, SUB, SUB ? 32'h0 : 32'hDEADBEEF);
        access("sw20z", 1'b0, 1'b1, F3_W,  32'h20, 32'h0, 1'b0, SUB ? 32'h0 : 32'hDEADBEEF);

        // Store aborted by reset in its first WAIT cycle
        @(negedge clk);
        bus_if.MemWrite = 1'b1;
        bus_if.Funct3   = F3_W;
        bus_if.Addr     = 32'h20;
        bus_if.WrData   = 32'h12345678;
        @(negedge clk);
        reset           = 1'b0;
        bus_if.MemWrite = 1'b0;
        #1;
        check("abort.stall", {31'b0, bus_if.Stall}, 32'd0);
        @(negedge clk);
        check("abort.done",  {31'b0, bus_if.Done}, 32'd0);
        check("abort.rdata", bus_if.RdData, 32'd0);
        reset = 1'b1;

        access("lw20",   1'b1, 1'b0, F3_W, 32'h20, 32'h0, 1'b0, 32'h0);
        access("rdwr40", 1'b1, 1'b1, F3_W, 32'h40, 32'hA5A5A5A5, 1'b0, 32'h0);
        access("lw40",   1'b1, 1'b0, F3_W, 32'h40, 32'h0, 1'b0, 32'hA5A5A5A5);
        access("swwrap", 1'b0, 1'b1, F3_W, 32'(4 * DEPTH + 4), 32'h11111111, 1'b0, 32'hA5A5A5A5);
        access("lw4",    1'b1, 1'b0, F3_W, 32'h4, 32'h0, 1'b0, 32'h11111111);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
